main_controller: RTL and testbench
==================================

MAIN_CONTROLLER -- requirements
Module: main_controller

Interface
REQ-001 SHALL have: clk  input  1  rising-edge clock.
REQ-002 SHALL have: rst  input  1  asynchronous active-high reset.
REQ-003 SHALL have: opcode  input  7  instruction bits [6:0] from the instruction register.
REQ-004 SHALL have: func3  input  3  instruction bits [14:12], used for branch condition only.
REQ-005 SHALL have: zero, neg  input  1 each  ALU flags (result==0, result<0 signed).
REQ-006 SHALL have: PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite  output  1 each  datapath enables and selects.
REQ-007 SHALL have: ResultSrc  output  2  00 ALUOut register, 01 memory data register, 10 live ALU result, 11 immediate.
REQ-008 SHALL have: AluOp  output  2  to ALU control: 00 add, 01 sub, 10 decode by func fields.
REQ-009 SHALL have: AluSrcA  output  2  00 PC, 01 OldPC, 10 rs1; AluSrcB  output  2  00 rs2, 01 imm, 10 constant 4.
REQ-010 SHALL have: ImmSrc  output  3  000 I, 001 S, 010 B, 011 J, 100 U.
REQ-011 SHALL have: instret  output  32  retired-instruction count (see Configuration).

Function
REQ-012 SHALL be a Moore FSM with states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, JALR1, JALR2, LUI; PCWrite in BRANCH is the only Mealy output.
REQ-013 SHALL drive all outputs not listed for a state to 0.
REQ-014 FETCH: AdrSrc=0, IRWrite=1, AluSrcA=00, AluSrcB=10, AluOp=00, ResultSrc=10, PCWrite=1; next DECODE.
REQ-015 DECODE: AluSrcA=01, AluSrcB=01, AluOp=00, ImmSrc=011 if opcode=1101111 else 010; next by opcode: 0000011/0100011->MEMADR, 0110011->EXECR, 0010011->EXECI, 1100011->BRANCH, 1101111->JAL, 1100111->JALR1, 0110111->LUI, any other->FETCH.
REQ-016 MEMADR: AluSrcA=10, AluSrcB=01, AluOp=00, ImmSrc=000 for load / 001 for store; next MEMREAD (load) or MEMWRITE (store).
REQ-017 MEMREAD: AdrSrc=1, ResultSrc=00; next MEMWB. MEMWB: ResultSrc=01, RegWrite=1; next FETCH. MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1; next FETCH.
REQ-018 EXECR: AluSrcA=10, AluSrcB=00, AluOp=10; EXECI: same but AluSrcB=01, ImmSrc=000; both next ALUWB. ALUWB: ResultSrc=00, RegWrite=1; next FETCH.
REQ-019 BRANCH: AluSrcA=10, AluSrcB=00, AluOp=01, ResultSrc=00; PCWrite=taken where func3 000:zero, 001:!zero, 100:neg, 101:!neg, other:0; next FETCH.
REQ-020 JAL: AluSrcA=01, AluSrcB=10, AluOp=00, ResultSrc=00, PCWrite=1; next ALUWB.
REQ-021 JALR1: AluSrcA=10, AluSrcB=01, ImmSrc=000, AluOp=00; next JALR2. JALR2: ResultSrc=00, PCWrite=1, AluSrcA=01, AluSrcB=10, AluOp=00; next ALUWB.
REQ-022 LUI: ImmSrc=100, ResultSrc=11, RegWrite=1; next FETCH.
REQ-023 Latency in cycles (FETCH to next FETCH): load 5, store 4, R/I 4, branch 3, JAL 4, JALR 5, LUI 3, illegal 2.
REQ-024 SHALL ignore input changes except at state evaluation; opcode sampled only in DECODE, func3/zero/neg only in BRANCH.

Reset
REQ-025 rst SHALL force state FETCH and instret=0 immediately, independent of clk, including mid-instruction; no partial writes SHALL be issued after rst asserts.
REQ-026 After rst deasserts, the first rising edge SHALL perform the FETCH actions of REQ-014.

Configuration
REQ-027 Macro CTRL_INSTRET_EN defined: instret SHALL increment by 1 on every transition into FETCH from MEMWB, MEMWRITE, ALUWB, BRANCH, LUI (not from DECODE on illegal opcode), wrapping 0xFFFFFFFF->0.
REQ-028 Macro CTRL_INSTRET_EN undefined: instret SHALL be constant 0 and no counter register SHALL be synthesised.

Verification
REQ-029 rst pulse mid-MEMREAD -> outputs return to FETCH values asynchronously, instret=0, MemWrite/RegWrite never 1.
REQ-030 opcode=0000011 -> states FETCH,DECODE,MEMADR,MEMREAD,MEMWB; RegWrite=1 only in cycle 5 with ResultSrc=01; instret +1.
REQ-031 opcode=1100011, func3=001, zero=0 -> PCWrite=1 in BRANCH; repeat with zero=1 -> PCWrite=0; 3 cycles each.
REQ-032 opcode=1100111 -> JALR2 has PCWrite=1, ResultSrc=00, then ALUWB RegWrite=1; total 5 cycles.
REQ-033 opcode=1111111 -> DECODE->FETCH in 2 cycles, no RegWrite/MemWrite/PCWrite beyond FETCH, instret unchanged.
REQ-034 With CTRL_INSTRET_EN, preload-free run of 3 LUI instructions -> instret=3 after 9 cycles; without macro instret=0.

Source files
------------

// File: rtl/main_controller.sv
`timescale 1ns/1ps
// Purpose : multicycle RV32 main control FSM (Moore, PCWrite in BRANCH is Mealy); optional CTRL_INSTRET_EN retired counter.
// Latency : FETCH to next FETCH = load 5, store 4, R/I 4, branch 3, JAL 4, JALR 5, LUI 3, illegal 2 cycles.
// Backpressure: none; free-running, no stall input, every state lasts exactly one cycle.
module main_controller (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  opcode,
  input  logic [2:0]  func3,
  input  logic        zero,
  input  logic        neg,
  output logic        PCWrite,
  output logic        AdrSrc,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        RegWrite,
  output logic [1:0]  ResultSrc,
  output logic [1:0]  AluOp,
  output logic [1:0]  AluSrcA,
  output logic [1:0]  AluSrcB,
  output logic [2:0]  ImmSrc,
  output logic [31:0] instret
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI,
    ALUWB, BRANCH, JAL, JALR1, JALR2, LUI
  } state_t;

  state_t state, state_nxt;
  logic   is_store;
  logic   br_taken;

  // State register; reset returns to FETCH immediately, even mid-instruction
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FETCH;
    else     state <= state_nxt;
  end

  // Remember load vs store in DECODE so opcode is never looked at again later
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 is_store <= 1'b0;
    else if (state == DECODE) is_store <= (opcode == OP_STORE);
  end

  // Branch condition, only consumed while in BRANCH
  always_comb begin
    br_taken = 1'b0;
    case (func3)
      3'b000:  br_taken = zero;
      3'b001:  br_taken = ~zero;
      3'b100:  br_taken = neg;
      3'b101:  br_taken = ~neg;
      default: br_taken = 1'b0;
    endcase
  end

  // Next-state selection
  always_comb begin
    state_nxt = FETCH;
    case (state)
      FETCH:    state_nxt = DECODE;
      DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: state_nxt = MEMADR;
          OP_RTYPE:          state_nxt = EXECR;
          OP_ITYPE:          state_nxt = EXECI;
          OP_BRANCH:         state_nxt = BRANCH;
          OP_JAL:            state_nxt = JAL;
          OP_JALR:           state_nxt = JALR1;
          OP_LUI:            state_nxt = LUI;
          default:           state_nxt = FETCH;
        endcase
      end
      MEMADR:   state_nxt = is_store ? MEMWRITE : MEMREAD;
      MEMREAD:  state_nxt = MEMWB;
      MEMWB:    state_nxt = FETCH;
      MEMWRITE: state_nxt = FETCH;
      EXECR:    state_nxt = ALUWB;
      EXECI:    state_nxt = ALUWB;
      ALUWB:    state_nxt = FETCH;
      BRANCH:   state_nxt = FETCH;
      JAL:      state_nxt = ALUWB;
      JALR1:    state_nxt = JALR2;
      JALR2:    state_nxt = ALUWB;
      LUI:      state_nxt = FETCH;
      default:  state_nxt = FETCH;
    endcase
  end

  // Per-state datapath controls; anything not set for a state stays 0
  always_comb begin
    PCWrite   = 1'b0;
    AdrSrc    = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    RegWrite  = 1'b0;
    ResultSrc = 2'b00;
    AluOp     = 2'b00;
    AluSrcA   = 2'b00;
    AluSrcB   = 2'b00;
    ImmSrc    = 3'b000;
    case (state)
      FETCH: begin
        IRWrite   = 1'b1;
        AluSrcB   = 2'b10;
        ResultSrc = 2'b10;
        PCWrite   = 1'b1;
      end
      DECODE: begin
        AluSrcA = 2'b01;
        AluSrcB = 2'b01;
        ImmSrc  = (opcode == OP_JAL) ? 3'b011 : 3'b010;
      end
      MEMADR: begin
        AluSrcA = 2'b10;
        AluSrcB = 2'b01;
        ImmSrc  = is_store ? 3'b001 : 3'b000;
      end
      MEMREAD: begin
        AdrSrc = 1'b1;
      end
      MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
      end
      MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
      end
      EXECR: begin
        AluSrcA = 2'b10;
        AluOp   = 2'b10;
      end
      EXECI: begin
        AluSrcA = 2'b10;
        AluSrcB = 2'b01;
        AluOp   = 2'b10;
      end
      ALUWB: begin
        RegWrite = 1'b1;
      end
      BRANCH: begin
        AluSrcA = 2'b10;
        AluOp   = 2'b01;
        PCWrite = br_taken;
      end
      JAL: begin
        AluSrcA = 2'b01;
        AluSrcB = 2'b10;
        PCWrite = 1'b1;
      end
      JALR1: begin
        AluSrcA = 2'b10;
        AluSrcB = 2'b01;
      end
      JALR2: begin
        PCWrite = 1'b1;
        AluSrcA = 2'b01;
        AluSrcB = 2'b10;
      end
      LUI: begin
        ImmSrc    = 3'b100;
        ResultSrc = 2'b11;
        RegWrite  = 1'b1;
      end
      default: begin
        PCWrite = 1'b0;
      end
    endcase
  end

`ifdef CTRL_INSTRET_EN
  logic retire;
  // Every state that completes an instruction goes straight back to FETCH
  assign retire = (state == MEMWB) || (state == MEMWRITE) || (state == ALUWB) ||
                  (state == BRANCH) || (state == LUI);

  // Retired-instruction counter, wraps naturally at 32 bits
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         instret <= 32'd0;
    else if (retire) instret <= instret + 32'd1;
  end
`else
  assign instret = 32'd0;
`endif

endmodule

// File: tb/tb_main_controller.sv
`timescale 1ns/1ps
// Purpose : randomized scoreboard bench for main_controller against an instruction-level model.
// Latency : one expected control word per clock, checked on the falling edge.
// Backpressure: none; the DUT presents outputs every cycle.
module tb_main_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  opcode = 7'd0;
  logic [2:0]  func3 = 3'd0;
  logic        zero = 1'b0;
  logic        neg = 1'b0;
  logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
  logic [1:0]  ResultSrc, AluOp, AluSrcA, AluSrcB;
  logic [2:0]  ImmSrc;
  logic [31:0] instret;

  main_controller dut (
    .clk(clk), .rst(rst), .opcode(opcode), .func3(func3), .zero(zero), .neg(neg),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .ResultSrc(ResultSrc), .AluOp(AluOp), .AluSrcA(AluSrcA),
    .AluSrcB(AluSrcB), .ImmSrc(ImmSrc), .instret(instret)
  );

  always #5 clk = ~clk;

  // Step kinds of an instruction, one per clock
  localparam int ST_F = 0, ST_DJ = 1, ST_DB = 2, ST_MAL = 3, ST_MAS = 4, ST_MR = 5,
                 ST_MWB = 6, ST_MW = 7, ST_ER = 8, ST_EI = 9, ST_AWB = 10, ST_BR = 11,
                 ST_JAL = 12, ST_J1 = 13, ST_J2 = 14, ST_LUI = 15;

  localparam logic [6:0] OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011, OP_R = 7'b0110011,
                         OP_I = 7'b0010011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111,
                         OP_JALR = 7'b1100111, OP_LUI = 7'b0110111;

  int          n_checks = 0;
  int          n_fail = 0;
  bit          mon_en = 1'b0;
  logic [15:0] exp_ctrl_q[$];
  logic [31:0] exp_ir_q[$];
  int          plan[$];
  logic [31:0] model_ir = 32'd0;

  wire [15:0] act_ctrl = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
                          ResultSrc, AluOp, AluSrcA, AluSrcB, ImmSrc};

  function automatic logic [15:0] mk(bit pcw, bit adr, bit mw, bit irw, bit rw,
                                     logic [1:0] rs, logic [1:0] aop, logic [1:0] sa,
                                     logic [1:0] sb, logic [2:0] imm);
    return {pcw, adr, mw, irw, rw, rs, aop, sa, sb, imm};
  endfunction

  function automatic bit taken(logic [2:0] f3, logic z, logic n);
    case (f3)
      3'b000:  return z;
      3'b001:  return !z;
      3'b100:  return n;
      3'b101:  return !n;
      default: return 1'b0;
    endcase
  endfunction

  // Control word the datapath must see in each step kind
  function automatic logic [15:0] exp_ctrl(int st, bit tk);
    case (st)
      ST_F:    return mk(1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b00, 2'b10, 3'b000);
      ST_DJ:   return mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b01, 2'b01, 3'b011);
      ST_DB:   return mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b01, 2'b01, 3'b010);
      ST_MAL:  return mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b10, 2'b01, 3'b000);
      ST_MAS:  return mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b10, 2'b01, 3'b001);
      ST_MR:   return mk(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000);
      ST_MWB:  return mk(0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 2'b00, 3'b000);
      ST_MW:   return mk(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000);
      ST_ER:   return mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b10, 2'b00, 3'b000);
      ST_EI:   return mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b10, 2'b01, 3'b000);
      ST_AWB:  return mk(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000);
      ST_BR:   return mk(tk, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b00, 3'b000);
      ST_JAL:  return mk(1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b01, 2'b10, 3'b000);
      ST_J1:   return mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b10, 2'b01, 3'b000);
      ST_J2:   return mk(1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b01, 2'b10, 3'b000);
      ST_LUI:  return mk(0, 0, 0, 0, 1, 2'b11, 2'b00, 2'b00, 2'b00, 3'b100);
      default: return 16'd0;
    endcase
  endfunction

  function automatic bit legal(logic [6:0] op);
    return op inside {OP_LOAD, OP_STORE, OP_R, OP_I, OP_BR, OP_JAL, OP_JALR, OP_LUI};
  endfunction

  // Sequence of step kinds an instruction walks through
  task automatic build_plan(input logic [6:0] op);
    plan.delete();
    plan.push_back(ST_F);
    plan.push_back(op == OP_JAL ? ST_DJ : ST_DB);
    case (op)
      OP_LOAD:  begin plan.push_back(ST_MAL); plan.push_back(ST_MR); plan.push_back(ST_MWB); end
      OP_STORE: begin plan.push_back(ST_MAS); plan.push_back(ST_MW); end
      OP_R:     begin plan.push_back(ST_ER); plan.push_back(ST_AWB); end
      OP_I:     begin plan.push_back(ST_EI); plan.push_back(ST_AWB); end
      OP_BR:    plan.push_back(ST_BR);
      OP_JAL:   begin plan.push_back(ST_JAL); plan.push_back(ST_AWB); end
      OP_JALR:  begin plan.push_back(ST_J1); plan.push_back(ST_J2); plan.push_back(ST_AWB); end
      OP_LUI:   plan.push_back(ST_LUI);
      default:  ;
    endcase
  endtask

  // Drive one cycle (entered just after a rising edge) and queue its expectation
  task automatic do_step(input int st, input logic [6:0] op, input bit fb,
                         input logic [2:0] f3f, input bit zf, input bit nf);
    opcode = (st == ST_DJ || st == ST_DB) ? op : 7'($urandom);
    if (st == ST_BR && fb) begin
      func3 = f3f; zero = zf; neg = nf;
    end else begin
      func3 = 3'($urandom); zero = 1'($urandom); neg = 1'($urandom);
    end
    exp_ctrl_q.push_back(exp_ctrl(st, taken(func3, zero, neg)));
    exp_ir_q.push_back(model_ir);
    @(posedge clk); #1;
  endtask

  task automatic run_instr(input logic [6:0] op, input bit fb, input logic [2:0] f3f,
                           input bit zf, input bit nf);
    build_plan(op);
    foreach (plan[i]) do_step(plan[i], op, fb, f3f, zf, nf);
`ifdef CTRL_INSTRET_EN
    if (legal(op)) model_ir = model_ir + 32'd1;
`endif
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Load interrupted by an asynchronous reset pulse in MEMREAD
  task automatic reset_mid_memread();
    build_plan(OP_LOAD);
    for (int i = 0; i < 3; i++) do_step(plan[i], OP_LOAD, 1'b0, 3'd0, 1'b0, 1'b0);
    mon_en = 1'b0;
    #2;
    check("memread_ctrl", {16'd0, act_ctrl}, {16'd0, exp_ctrl(ST_MR, 1'b0)});
    rst = 1'b1;
    #1;
    check("async_rst_ctrl", {16'd0, act_ctrl}, {16'd0, exp_ctrl(ST_F, 1'b0)});
    check("async_rst_instret", instret, 32'd0);
    model_ir = 32'd0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check("rst_no_writes", {30'd0, MemWrite, RegWrite}, 32'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    mon_en = 1'b1;
  endtask

  // Monitor: one expected control word and count per clock
  always @(negedge clk) begin
    if (mon_en) begin
      if (exp_ctrl_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL scoreboard_empty: DUT output %h with nothing expected at %0t", act_ctrl, $time);
      end else begin
        logic [15:0] ec;
        logic [31:0] ei;
        ec = exp_ctrl_q.pop_front();
        ei = exp_ir_q.pop_front();
        check("ctrl", {16'd0, act_ctrl}, {16'd0, ec});
        check("instret", instret, ei);
      end
    end
  end

  // Any write strobe while reset is held is an error
  always @(posedge MemWrite or posedge RegWrite) begin
    if (rst) begin
      n_checks++;
      n_fail++;
      $display("FAIL write_in_reset: MemWrite=%b RegWrite=%b expected 0 0 at %0t", MemWrite, RegWrite, $time);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  logic [6:0] legal_ops[8];

  initial begin
    legal_ops = '{OP_LOAD, OP_STORE, OP_R, OP_I, OP_BR, OP_JAL, OP_JALR, OP_LUI};
    rst = 1'b1;
    #12;
    check("reset_ctrl", {16'd0, act_ctrl}, {16'd0, exp_ctrl(ST_F, 1'b0)});
    check("reset_instret", instret, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    mon_en = 1'b1;

    // Directed coverage of every instruction class
    run_instr(OP_LOAD, 0, 3'd0, 0, 0);
    run_instr(OP_STORE, 0, 3'd0, 0, 0);
    run_instr(OP_R, 0, 3'd0, 0, 0);
    run_instr(OP_I, 0, 3'd0, 0, 0);
    run_instr(OP_BR, 1, 3'b001, 0, 0);
    run_instr(OP_BR, 1, 3'b001, 1, 0);
    run_instr(OP_BR, 1, 3'b000, 1, 0);
    run_instr(OP_BR, 1, 3'b100, 0, 1);
    run_instr(OP_BR, 1, 3'b101, 0, 1);
    run_instr(OP_BR, 1, 3'b010, 1, 1);
    run_instr(OP_JAL, 0, 3'd0, 0, 0);
    run_instr(OP_JALR, 0, 3'd0, 0, 0);
    run_instr(OP_LUI, 0, 3'd0, 0, 0);
    run_instr(7'b1111111, 0, 3'd0, 0, 0);

    // Random instruction mix including illegal opcodes
    for (int k = 0; k < 300; k++) begin
      int sel;
      logic [6:0] op;
      sel = int'($urandom_range(0, 9));
      if (sel < 8) op = legal_ops[sel];
      else begin
        op = 7'($urandom);
        while (legal(op)) op = 7'($urandom);
      end
      run_instr(op, 0, 3'd0, 0, 0);
    end

    // Reset mid-load, then three LUIs from a fresh count
    reset_mid_memread();
    run_instr(OP_LUI, 0, 3'd0, 0, 0);
    run_instr(OP_LUI, 0, 3'd0, 0, 0);
    run_instr(OP_LUI, 0, 3'd0, 0, 0);
    run_instr(7'b0000000, 0, 3'd0, 0, 0);
    run_instr(OP_STORE, 0, 3'd0, 0, 0);

    mon_en = 1'b0;
    check("scoreboard_drained", exp_ctrl_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
